// File: rtl/wb_slave_pkg.sv
// -----------------------------------------------------------------------------
// wb_slave_pkg
// Shared definitions for the Wishbone slave memory controller: FSM state
// encoding, bus word geometry, wait-state limit and the doorbell word offset.
// No ports (package).
// -----------------------------------------------------------------------------
package wb_slave_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2,
        ERR  = 2'd3
    } slave_state_e;

    localparam int WB_WORD_BYTES   = 4;
    localparam int MAX_WAIT_STATES = 7;

    // The doorbell is the last word of the RAM.
    function automatic int unsigned doorbell_idx(input int unsigned words);
        return words - 1;
    endfunction

endpackage

// File: rtl/wb_byte_lane_ram.sv
// -----------------------------------------------------------------------------
// wb_byte_lane_ram
// Single-port words x 32 RAM with per-byte write enables and a registered
// (synchronous) read port. Read returns the old word on a same-address write.
// Ports:
//   clk    in   clock
//   addr   in   word address
//   wdata  in   write data
//   we     in   byte-lane write enables, bit n -> wdata[8n+7:8n]
//   rdata  out  registered read data
// -----------------------------------------------------------------------------
module wb_byte_lane_ram
    import wb_slave_pkg::*;
#(
    parameter int words = 1024,
    parameter int aw    = $clog2(words)
) (
    input  logic                         clk,
    input  logic [aw-1:0]                addr,
    input  logic [8*WB_WORD_BYTES-1:0]   wdata,
    input  logic [WB_WORD_BYTES-1:0]     we,
    output logic [8*WB_WORD_BYTES-1:0]   rdata
);

    logic [8*WB_WORD_BYTES-1:0] mem [words];

    // NOTE: the storage array has no reset branch; resetting a RAM would turn
    // it into a huge register file and prevents block-RAM inference.
    always_ff @(posedge clk) begin
        for (int b = 0; b < WB_WORD_BYTES; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/wb_slave_mem_ctrl.sv
// -----------------------------------------------------------------------------
// wb_slave_mem_ctrl
// Wishbone slave memory controller: word-addressed byte-lane RAM with
// programmable wait states, range/alignment error termination and a sticky
// doorbell interrupt on the last RAM word.
// Ports:
//   clk      in   bus clock
//   rst      in   synchronous active-high reset
//   s_addr   in   byte address ([27:2] = word offset, [1:0] must be 0)
//   s_wdata  in   write data
//   s_sel    in   byte selects ([3:0] used)
//   s_cyc    in   cycle valid
//   s_stb    in   this slave's strobe
//   s_we     in   1 = write, 0 = read
//   s_rdata  out  read data, zero unless s_ack
//   s_ack    out  normal termination (one cycle)
//   s_err    out  error termination (one cycle)
//   s_rty    out  retry, tied low
//   irq      out  doorbell interrupt (level, sticky)
// -----------------------------------------------------------------------------
module wb_slave_mem_ctrl
    import wb_slave_pkg::*;
#(
    parameter int data_width  = 32,
    parameter int addr_width  = 32,
    parameter int mem_words   = 1024,
    parameter int wait_states = 0,
    parameter int slave_id    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [addr_width-1:0] s_addr,
    input  logic [data_width-1:0] s_wdata,
    input  logic [7:0]            s_sel,
    input  logic                  s_cyc,
    input  logic                  s_stb,
    input  logic                  s_we,
    output logic [data_width-1:0] s_rdata,
    output logic                  s_ack,
    output logic                  s_err,
    output logic                  s_rty,
    output logic                  irq
);

    localparam int AW = $clog2(mem_words);
    localparam int CW = $clog2(MAX_WAIT_STATES + 1);
    localparam logic [AW-1:0] DB_IDX = AW'(doorbell_idx(mem_words));

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_WAIT = WAIT;
    localparam logic [1:0] S_ACK  = ACK;
    localparam logic [1:0] S_ERR  = ERR;

    logic [1:0]               state;
    logic [1:0]               state_nxt;
    logic [CW-1:0]            wcnt;
    logic [AW-1:0]            lat_addr;
    logic [data_width-1:0]    lat_wdata;
    logic [3:0]               lat_sel;
    logic                     lat_we;

    logic                     req;
    logic                     bad_addr;
    logic [AW-1:0]            ram_addr;
    logic [3:0]               ram_we;
    logic [data_width-1:0]    ram_q;
    logic [data_width-1:0]    lane_mask;

    assign req      = s_cyc & s_stb;
    assign bad_addr = (s_addr[1:0] != 2'b00) ||
                      ({6'b0, s_addr[27:2]} >= 32'(mem_words));

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (bad_addr)              state_nxt = S_ERR;
                    else if (wait_states == 0) state_nxt = S_ACK;
                    else                       state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // Master withdrawing the strobe aborts: no ack, no write.
                if (!req)                   state_nxt = S_IDLE;
                else if (wcnt == CW'(1))    state_nxt = S_ACK;
            end
            default: state_nxt = S_IDLE;  // ACK and ERR last one cycle
        endcase
    end

    always_comb begin
        lane_mask = '0;
        for (int b = 0; b < WB_WORD_BYTES; b++) begin
            lane_mask[8*b +: 8] = {8{lat_sel[b]}};
        end
    end

    // Decode straight off the bus in IDLE so that with zero wait states the
    // synchronous RAM read lands together with the ack.
    assign ram_addr = (state == S_IDLE) ? s_addr[AW+1:2] : lat_addr;
    // The write commits on the edge leaving ACK; reset at that edge wins.
    assign ram_we   = (state == S_ACK && lat_we && !rst) ? lat_sel : 4'b0000;

    wb_byte_lane_ram #(
        .words (mem_words)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .wdata (lat_wdata),
        .we    (ram_we),
        .rdata (ram_q)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wcnt      <= '0;
            s_ack     <= 1'b0;
            s_err     <= 1'b0;
            irq       <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_sel   <= '0;
            lat_we    <= 1'b0;
        end else begin
            state <= state_nxt;
            s_ack <= (state_nxt == S_ACK);
            s_err <= (state_nxt == S_ERR);

            if (state == S_IDLE && req && !bad_addr) begin
                wcnt      <= CW'(wait_states);
                lat_addr  <= s_addr[AW+1:2];
                lat_wdata <= s_wdata;
                lat_sel   <= s_sel[3:0];
                lat_we    <= s_we;
            end else if (state == S_WAIT) begin
                wcnt <= wcnt - CW'(1);
            end

            if (state == S_ACK && lat_addr == DB_IDX) begin
                if (lat_we) irq <= |(lat_wdata & lane_mask);
                else        irq <= 1'b0;
            end
        end
    end

    assign s_rdata = s_ack ? ram_q : '0;
    assign s_rty   = 1'b0;

    // Upper select lanes, the pre-decoded address nibble and slave_id carry
    // no function inside this block.
    logic unused_bits;
    assign unused_bits = ^{s_sel[7:4], s_addr[addr_width-1:28]} ^ (slave_id != 0);

endmodule

// File: tb/tb_wb_slave_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wb_slave_mem_ctrl
// Two instances: dut 0 with zero wait states, dut 1 with three. Stimulus pushes
// expected terminations (kind, cycle, read data) into per-instance queues; a
// negedge monitor pops and compares whenever ack or err is seen.
// -----------------------------------------------------------------------------
module tb_wb_slave_mem_ctrl;

    typedef struct {
        bit          is_err;
        bit          chk_data;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        b_rst   [2];
    logic [31:0] b_addr  [2];
    logic [31:0] b_wdata [2];
    logic [7:0]  b_sel   [2];
    logic        b_cyc   [2];
    logic        b_stb   [2];
    logic        b_we    [2];
    logic [31:0] rdata   [2];
    logic        ack     [2];
    logic        err     [2];
    logic        rty     [2];
    logic        irq     [2];

    exp_t q0[$];
    exp_t q1[$];
    int   cyc_cnt = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic prev_resp [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    wb_slave_mem_ctrl #(.wait_states(0), .slave_id(0)) dut0 (
        .clk(clk), .rst(b_rst[0]), .s_addr(b_addr[0]), .s_wdata(b_wdata[0]),
        .s_sel(b_sel[0]), .s_cyc(b_cyc[0]), .s_stb(b_stb[0]), .s_we(b_we[0]),
        .s_rdata(rdata[0]), .s_ack(ack[0]), .s_err(err[0]), .s_rty(rty[0]),
        .irq(irq[0])
    );

    wb_slave_mem_ctrl #(.wait_states(3), .slave_id(1)) dut1 (
        .clk(clk), .rst(b_rst[1]), .s_addr(b_addr[1]), .s_wdata(b_wdata[1]),
        .s_sel(b_sel[1]), .s_cyc(b_cyc[1]), .s_stb(b_stb[1]), .s_we(b_we[1]),
        .s_rdata(rdata[1]), .s_ack(ack[1]), .s_err(err[1]), .s_rty(rty[1]),
        .irq(irq[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    task automatic push_exp(input int i, input bit is_err, input bit chk,
                            input logic [31:0] d, input int cyc);
        exp_t e;
        e.is_err = is_err; e.chk_data = chk; e.data = d; e.cyc = cyc;
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // Monitor: compare every termination against the scoreboard.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ack[i] === 1'b1 || err[i] === 1'b1) begin
                exp_t e;
                bit   have;
                have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
                check($sformatf("dut%0d_ack_err_exclusive", i), {31'b0, ack[i] & err[i]}, 32'd0);
                check($sformatf("dut%0d_no_back_to_back", i), {31'b0, prev_resp[i]}, 32'd0);
                if (!have) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL dut%0d_unexpected_response: got ack=%0b err=%0b expected none (cycle %0d)",
                             i, ack[i], err[i], cyc_cnt);
                end else begin
                    if (i == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    check($sformatf("dut%0d_err_flag", i), {31'b0, err[i]}, {31'b0, e.is_err});
                    check($sformatf("dut%0d_resp_cycle", i), cyc_cnt, e.cyc);
                    if (e.chk_data) check($sformatf("dut%0d_rdata", i), rdata[i], e.data);
                end
                prev_resp[i] <= 1'b1;
            end else begin
                prev_resp[i] <= 1'b0;
            end
        end
    end

    // Bounded wait for ack/err; returns #1 after the edge on which it rose.
    task automatic wait_resp(input int i);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (ack[i] || err[i]) return;
        end
        n_checks++;
        n_errors++;
        $display("FAIL dut%0d_resp_timeout: got no termination expected ack or err", i);
    endtask

    // Single transfer; called #1 after a posedge with the DUT in IDLE.
    task automatic xfer(input int i, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [7:0] sel,
                        input bit exp_err, input bit chk, input logic [31:0] exp_d);
        int w;
        w = (i == 0 || exp_err) ? 0 : 3;
        push_exp(i, exp_err, chk, exp_d, cyc_cnt + 1 + w);
        b_addr[i] = addr; b_wdata[i] = wdata; b_sel[i] = sel; b_we[i] = we;
        b_cyc[i] = 1'b1; b_stb[i] = 1'b1;
        wait_resp(i);
        b_cyc[i] = 1'b0; b_stb[i] = 1'b0; b_we[i] = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [31:0] burst_data [4];

    initial begin
        burst_data[0] = 32'h1000_0001;
        burst_data[1] = 32'h2000_0002;
        burst_data[2] = 32'h3000_0003;
        burst_data[3] = 32'h4000_0004;
        for (int i = 0; i < 2; i++) begin
            b_rst[i] = 1'b1; b_addr[i] = '0; b_wdata[i] = '0; b_sel[i] = '0;
            b_cyc[i] = 1'b0; b_stb[i] = 1'b0; b_we[i] = 1'b0; prev_resp[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("dut%0d_reset_ack", i),   {31'b0, ack[i]}, 32'd0);
            check($sformatf("dut%0d_reset_err", i),   {31'b0, err[i]}, 32'd0);
            check($sformatf("dut%0d_reset_rty", i),   {31'b0, rty[i]}, 32'd0);
            check($sformatf("dut%0d_reset_irq", i),   {31'b0, irq[i]}, 32'd0);
            check($sformatf("dut%0d_reset_rdata", i), rdata[i], 32'd0);
        end
        b_rst[0] = 1'b0; b_rst[1] = 1'b0;
        @(posedge clk); #1;

        // Write then read, byte lanes, empty select (W = 0).
        xfer(0, 1, 32'h10, 32'hDEAD_BEEF, 8'h0F, 0, 0, '0);
        xfer(0, 0, 32'h10, '0,            8'h0F, 0, 1, 32'hDEAD_BEEF);
        xfer(0, 1, 32'h10, 32'h1122_3344, 8'h05, 0, 0, '0);
        xfer(0, 0, 32'h10, '0,            8'h0F, 0, 1, 32'hDE22_BE44);
        xfer(0, 1, 32'h10, 32'hFFFF_FFFF, 8'h00, 0, 0, '0);
        xfer(0, 0, 32'h10, '0,            8'h00, 0, 1, 32'hDE22_BE44);

        // Error terminations leave RAM untouched.
        xfer(0, 0, 32'h1000, '0,            8'h0F, 1, 0, '0);
        xfer(0, 0, 32'h0002, '0,            8'h0F, 1, 0, '0);
        xfer(0, 1, 32'h0012, 32'hFFFF_FFFF, 8'h0F, 1, 0, '0);
        xfer(0, 0, 32'h10,   '0,            8'h0F, 0, 1, 32'hDE22_BE44);

        // Doorbell at word 1023.
        xfer(0, 1, 32'hFFC, 32'h1, 8'h0F, 0, 0, '0);
        check("irq_set_by_write", {31'b0, irq[0]}, 32'd1);
        xfer(0, 0, 32'hFFC, '0, 8'h0F, 0, 1, 32'h1);
        check("irq_cleared_by_read", {31'b0, irq[0]}, 32'd0);
        xfer(0, 1, 32'hFFC, 32'h1, 8'h0F, 0, 0, '0);
        check("irq_set_again", {31'b0, irq[0]}, 32'd1);
        xfer(0, 1, 32'hFFC, 32'h0, 8'h0F, 0, 0, '0);
        check("irq_cleared_by_zero_write", {31'b0, irq[0]}, 32'd0);

        // Wait states (W = 3) and abort during WAIT.
        xfer(1, 1, 32'h40, 32'hCAFE_F00D, 8'h0F, 0, 0, '0);
        xfer(1, 0, 32'h40, '0,            8'h0F, 0, 1, 32'hCAFE_F00D);
        xfer(1, 0, 32'h1000, '0,          8'h0F, 1, 0, '0);
        b_addr[1] = 32'h40; b_wdata[1] = 32'h1234_5678; b_sel[1] = 8'h0F; b_we[1] = 1'b1;
        b_cyc[1] = 1'b1; b_stb[1] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        b_stb[1] = 1'b0; b_cyc[1] = 1'b0; b_we[1] = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        xfer(1, 0, 32'h40, '0, 8'h0F, 0, 1, 32'hCAFE_F00D);

        // Preload burst words, raise irq, then reset during a write's WAIT.
        for (int k = 0; k < 4; k++) xfer(1, 1, 32'h80 + 4*k, burst_data[k], 8'h0F, 0, 0, '0);
        xfer(1, 1, 32'hFFC, 32'hA5, 8'h01, 0, 0, '0);
        check("dut1_irq_before_reset", {31'b0, irq[1]}, 32'd1);
        b_addr[1] = 32'h80; b_wdata[1] = 32'hBAD0_BAD0; b_sel[1] = 8'h0F; b_we[1] = 1'b1;
        b_cyc[1] = 1'b1; b_stb[1] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        b_rst[1] = 1'b1;
        @(posedge clk); #1;
        check("midreset_ack",   {31'b0, ack[1]}, 32'd0);
        check("midreset_err",   {31'b0, err[1]}, 32'd0);
        check("midreset_irq",   {31'b0, irq[1]}, 32'd0);
        check("midreset_rdata", rdata[1], 32'd0);
        b_rst[1] = 1'b0; b_cyc[1] = 1'b0; b_stb[1] = 1'b0; b_we[1] = 1'b0;
        @(posedge clk); #1;
        xfer(1, 0, 32'h80, '0, 8'h0F, 0, 1, burst_data[0]);

        // Four-word burst read with strobe held: acks W+2 = 5 cycles apart.
        b_addr[1] = 32'h80; b_sel[1] = 8'h0F; b_we[1] = 1'b0;
        b_cyc[1] = 1'b1; b_stb[1] = 1'b1;
        push_exp(1, 0, 1, burst_data[0], cyc_cnt + 1 + 3);
        for (int k = 0; k < 4; k++) begin
            wait_resp(1);
            if (k < 3) begin
                b_addr[1] = 32'h80 + 4*(k+1);
                push_exp(1, 0, 1, burst_data[k+1], cyc_cnt + 2 + 3);
            end
        end
        b_cyc[1] = 1'b0; b_stb[1] = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        check("dut0_scoreboard_drained", q0.size(), 32'd0);
        check("dut1_scoreboard_drained", q1.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Absolute time guard.
    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion expected finish");
        $fatal(1);
    end

endmodule

// File: doc/wb_slave_mem_ctrl.md
# wb_slave_mem_ctrl

Wishbone slave memory controller on one slave port of the wishbone syscon interconnect. It consumes the shared slave-side bus (`s_addr`, `s_wdata`, `s_sel`, `s_cyc`, `s_we`) plus its own decoded strobe bit. It returns `s_rdata`/`s_ack`/`s_err`/`s_rty` and one interrupt bit, serving as the target device for the BFM's read/write cycles. It provides word-addressed byte-lane RAM with programmable wait states, range/alignment error responses, and a doorbell interrupt.

## Interface
- `data_width`, 32, bus data width; must be 32.
- `addr_width`, 32, bus address width.
- `mem_words`, 1024, RAM depth in 32-bit words; power of two, max 2^18.
- `wait_states`, 0, extra cycles before ack; 0–7.
- `slave_id`, 0, index of this slave in syscon; documentation and irq bit position only.
- `clk`  in  1  bus clock, driven by syscon.
- `rst`  in  1  synchronous, active-high reset.
- `s_addr`  in  addr_width  byte address; `[31:28]` already decoded upstream, `[27:2]` is the word offset here.
- `s_wdata`  in  data_width  write data.
- `s_sel`  in  8  byte selects; only `[3:0]` used, bit n enables byte lane n.
- `s_cyc`  in  1  cycle valid.
- `s_stb`  in  1  this slave's strobe, which is `s_stb[slave_id]` of syscon.
- `s_we`  in  1  1 = write, 0 = read.
- `s_rdata`  out  data_width  read data, valid only while `s_ack`.
- `s_ack`  out  1  normal termination.
- `s_err`  out  1  error termination.
- `s_rty`  out  1  retry; constant 0.
- `irq`  out  1  doorbell interrupt, level, sticky.

## Operation
- **Request:** `s_cyc && s_stb` sampled at a rising edge while in IDLE.
- **FSM states:** IDLE, WAIT, ACK, ERR.
- **IDLE decode:**
  - Go to ERR if `s_addr[1:0] != 0` or `s_addr[27:2] >= mem_words`.
  - Otherwise load `wcnt = wait_states`, latch address, data, we and sel, then go to ACK if `wait_states == 0`, else WAIT.
- **WAIT:**
  - Decrement `wcnt` each cycle; go to ACK when it reaches 1.
  - If `s_cyc` or `s_stb` is low at an edge, go to IDLE (abort): no ack, no memory write.
- **ACK:**
  - `s_ack = 1` for exactly one cycle; go to IDLE.
  - Write commits on the edge that leaves ACK, for lanes with `s_sel[n] = 1` only.
  - `s_sel[3:0] == 0` write is acked with no change.
- **ERR:** `s_err = 1` for exactly one cycle; go to IDLE. Memory and irq are unchanged.
- **Read data:** registered full word (sel ignored), captured from the latched address, presented with ack. `s_rdata` is 0 when not acking.
- **Doorbell:** word offset `mem_words-1`, which is also ordinary RAM storage.
  - Acked write with any non-zero written byte sets `irq`.
  - Acked write of all-zero data (selected lanes) clears `irq`.
  - Acked read clears `irq` after the ack cycle.
- **Block transfers:** master holds `s_cyc`/`s_stb` and advances `s_addr` after each ack. The mandatory IDLE cycle after ACK re-samples the new address.
- **Reset:**
  - Next edge: state IDLE, `s_ack = s_err = s_rty = 0`, `s_rdata = 0`, `irq = 0`, `wcnt = 0`.
  - RAM contents are not reset.
  - Reset mid-transfer discards that transfer; a pending write is not committed.

## Timing
- Request sampled at edge E: `s_ack` (or `s_err`) is high from E+1+W to E+2+W, with W = `wait_states`; ERR always uses W = 0.
- Back-to-back throughput is one access per W+2 cycles.
- Ack and err never assert together, and never for two consecutive cycles.
- All outputs are registered; no combinational input-to-output path.
- A write is visible to a read requested at E+2+W or later.

## Structure
- **Package `wb_slave_pkg`:** `slave_state_e` {IDLE, WAIT, ACK, ERR}, `WB_WORD_BYTES = 4`, `MAX_WAIT_STATES = 7`, and the doorbell-offset function `doorbell_idx(mem_words)`.
- **Sub-module `wb_byte_lane_ram`:** single-port, `mem_words × 32`, 4 byte-write enables, synchronous read, no reset.
- **Top:** FSM, wait counter, latch registers, irq flag.

## Test plan
- **Write then read:** `wait_states = 0`, write `0xDEADBEEF` @ `0x0000_0010` sel `0xF`, then read -> ack 1 cycle after each request, read returns `0xDEADBEEF`.
- **Byte-lane write:** sel `0x5` writes `0x11223344` over `0xDEADBEEF` -> read `0xDE22BE44`. Then sel `0x0` write -> acked, data unchanged.
- **Wait states:** `wait_states = 3` -> ack exactly 4 cycles after request. Drop `s_stb` during WAIT -> no ack, location unchanged.
- **Error responses:** read @ word `mem_words` (`0x0000_1000`) and @ `0x0000_0002` -> `s_err` one cycle each, `s_ack` stays 0, RAM unchanged.
- **Doorbell:** write `0x1` to word 1023 -> `irq = 1` after ack. Read of word 1023 returns `0x1` and `irq = 0` next cycle. Write `0x0` while irq is set -> irq cleared.
- **Reset and burst:** assert `rst` during WAIT of a write -> outputs 0 next edge, no write. Then a 4-word burst read with `s_stb` held -> 4 acks spaced W+2 cycles apart.
